// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if
// Bundles the control/status signals between the instruction sequencer and
// the 8-bit datapath (IR, 8x8 register file, ALU) plus the program memory.
//
// Signals (direction as seen by the sequencer, modport master):
//   ir_in       in   16      current IR contents
//   alu_flag    in   4       ALU flags {Z,C,N,O}, Z = bit 3
//   mem_addr    out  ADDR_W  memory byte address
//   mem_rd      out  1       memory read strobe
//   ir_enable   out  1       IR enable
//   ir_funsel   out  2       IR function select (01 = load)
//   ir_lh       out  1       IR byte select (0 = [7:0], 1 = [15:8])
//   rf_funsel   out  2       regfile function select (01 = load)
//   rf_rsel     out  4       one-hot write select, bit3 = R1 .. bit0 = R4
//   rf_o1sel    out  3       regfile read port 1 select
//   rf_o2sel    out  3       regfile read port 2 select
//   rf_load_sel out  1       regfile load source (0 = ALU, 1 = ir_in[7:0])
//   alu_funsel  out  4       ALU function select
//   flags       out  4       latched flag register
//   t_state     out  2       current sequencer state (0 T0, 1 T1, 2 T2, 3 HALT)
//   halted      out  1       high in HALT
//
// Handshake: there is no valid/ready pair here. Every strobe (mem_rd,
// ir_enable, rf_funsel/rf_rsel) is a single-cycle command that the datapath
// must act on at the next rising clk edge; memory returns its byte in the
// same cycle mem_rd is high, with no back-pressure.

interface ctrl_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [15:0]       ir_in;
  logic [3:0]        alu_flag;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              ir_enable;
  logic [1:0]        ir_funsel;
  logic              ir_lh;
  logic [1:0]        rf_funsel;
  logic [3:0]        rf_rsel;
  logic [2:0]        rf_o1sel;
  logic [2:0]        rf_o2sel;
  logic              rf_load_sel;
  logic [3:0]        alu_funsel;
  logic [3:0]        flags;
  logic [1:0]        t_state;
  logic              halted;

  modport master (
    input  ir_in, alu_flag,
    output mem_addr, mem_rd, ir_enable, ir_funsel, ir_lh,
           rf_funsel, rf_rsel, rf_o1sel, rf_o2sel, rf_load_sel,
           alu_funsel, flags, t_state, halted
  );

  modport slave (
    output ir_in, alu_flag,
    input  mem_addr, mem_rd, ir_enable, ir_funsel, ir_lh,
           rf_funsel, rf_rsel, rf_o1sel, rf_o2sel, rf_load_sel,
           alu_funsel, flags, t_state, halted
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
// Instruction sequencer for the 8-bit datapath. Holds the PC, fetches each
// 16-bit instruction as two bytes (low then high) into the IR, then spends
// one cycle executing it: ALU op, LDI, BRZ, NOP or HLT.
//
// Ports:
//   clk   in  1   system clock, rising edge
//   rst   in  1   synchronous active-high reset
//   step  in  1   single-step request (only when SINGLE_STEP_EN is defined)
//   bus   ctrl_sequencer_if.master  datapath control/status bundle
//
// Optional feature macro: SINGLE_STEP_EN. When defined, T0 waits for
// step = 1 before fetching, so one instruction runs per step pulse.
//
// Instruction: [15:12] opcode, [11:10] Rd, [9:8] Rs1, [7:6] Rs2, [7:0] imm8.
// Control outputs are combinational from state and ir_in and are all forced
// to 0 while rst is high; flags/t_state/halted show the registered state.

module ctrl_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst,
`ifdef SINGLE_STEP_EN
  input  logic step,
`endif
  ctrl_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_T0   = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [3:0] OP_ALU_MAX = 4'hB;
  localparam logic [3:0] OP_LDI     = 4'hC;
  localparam logic [3:0] OP_BRZ     = 4'hD;
  localparam logic [3:0] OP_HLT     = 4'hF;
  localparam logic [1:0] FUN_LOAD   = 2'b01;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        flags_q;
  logic              fetch_go;

  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs1;
  logic [1:0] rs2;
  logic [7:0] imm8;

  assign opcode = bus.ir_in[15:12];
  assign rd     = bus.ir_in[11:10];
  assign rs1    = bus.ir_in[9:8];
  assign rs2    = bus.ir_in[7:6];
  assign imm8   = bus.ir_in[7:0];

`ifdef SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  // Register code 00..11 = R1..R4, and R1 sits on the MSB of rf_rsel.
  function automatic logic [3:0] rsel_onehot(input logic [1:0] code);
    logic [3:0] sel;
    case (code)
      2'b00:   sel = 4'b1000;
      2'b01:   sel = 4'b0100;
      2'b10:   sel = 4'b0010;
      default: sel = 4'b0001;
    endcase
    return sel;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_T0;
      pc      <= RESET_PC;
      flags_q <= 4'h0;
    end else begin
      case (state)
        S_T0: begin
          if (fetch_go) begin
            pc    <= pc + ADDR_W'(1);
            state <= S_T1;
          end
        end
        S_T1: begin
          pc    <= pc + ADDR_W'(1);
          state <= S_T2;
        end
        S_T2: begin
          state <= (opcode == OP_HLT) ? S_HALT : S_T0;
          if (opcode <= OP_ALU_MAX) flags_q <= bus.alu_flag;
          // BRZ tests the flags latched by an earlier instruction.
          if (opcode == OP_BRZ && flags_q[3]) pc <= ADDR_W'(imm8);
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: state <= S_T0;
      endcase
    end
  end

  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_rd      = 1'b0;
    bus.ir_enable   = 1'b0;
    bus.ir_funsel   = 2'b00;
    bus.ir_lh       = 1'b0;
    bus.rf_funsel   = 2'b00;
    bus.rf_rsel     = 4'b0000;
    bus.rf_o1sel    = 3'b000;
    bus.rf_o2sel    = 3'b000;
    bus.rf_load_sel = 1'b0;
    bus.alu_funsel  = 4'h0;
    if (!rst) begin
      case (state)
        S_T0, S_T1: begin
          if (state == S_T1 || fetch_go) begin
            bus.mem_addr  = pc;
            bus.mem_rd    = 1'b1;
            bus.ir_enable = 1'b1;
            bus.ir_funsel = FUN_LOAD;
            bus.ir_lh     = (state == S_T1);
          end
        end
        S_T2: begin
          if (opcode <= OP_ALU_MAX) begin
            bus.rf_o1sel   = {1'b1, rs1};
            bus.rf_o2sel   = {1'b1, rs2};
            bus.alu_funsel = opcode;
            bus.rf_funsel  = FUN_LOAD;
            bus.rf_rsel    = rsel_onehot(rd);
          end else if (opcode == OP_LDI) begin
            bus.rf_funsel   = FUN_LOAD;
            bus.rf_rsel     = rsel_onehot(rd);
            bus.rf_load_sel = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.flags   = flags_q;
  assign bus.t_state = state;
  assign bus.halted  = (state == S_HALT);

endmodule
